// File: rtl/cache_types.sv
// Shared types and constants for the cache refill controller.
//   refill_state_t : refill FSM states
//   refill_req_t   : miss context captured when a miss is accepted
//   tag_width()    : tag width for a given set-index width (27 - set_bits)
package cache_types;

  localparam int unsigned ADDR_BITS   = 32;
  localparam int unsigned LINE_BITS   = 256;
  localparam int unsigned OFFSET_BITS = 5;
  // Tag field of the tag array; narrower tags are zero-extended into it.
  localparam int unsigned TAG_FIELD_W = 23;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StFill
  } refill_state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0]   addr;
    logic [1:0]             way;
    logic [TAG_FIELD_W-1:0] vtag;
    logic [LINE_BITS-1:0]   vdata;
  } refill_req_t;

  function automatic int unsigned tag_width(input int unsigned set_bits);
    return ADDR_BITS - OFFSET_BITS - set_bits;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Bus bundle between cache stage 2, the refill controller, memory (DFP) and the SRAM arrays.
//   master : the refill controller (drives DFP requests, SRAM write ports and replay pulses)
//   slave  : the environment (stage 2 requests, victim info, DFP responses)
interface cache_refill_ctrl_if #(
  parameter int unsigned SET_BITS = 4
) ();
  import cache_types::*;

  localparam int unsigned TAG_W = tag_width(SET_BITS);

  // Stage 2 request side
  logic                 miss_req;
  logic                 hit_write;
  logic [1:0]           hit_way;
  logic [31:0]          req_addr;
  logic [3:0]           req_wmask;
  logic [31:0]          req_wdata;
  logic [1:0]           victim_way;
  logic                 victim_valid;
  logic                 victim_dirty;
  logic [TAG_W-1:0]     victim_tag;
  logic [LINE_BITS-1:0] victim_data;
  // Memory side
  logic [31:0]          dfp_addr;
  logic                 dfp_read;
  logic                 dfp_write;
  logic [LINE_BITS-1:0] dfp_wdata;
  logic [LINE_BITS-1:0] dfp_rdata;
  logic                 dfp_resp;
  // SRAM write ports
  logic [3:0]           data_web;
  logic [31:0]          data_wmask;
  logic [LINE_BITS-1:0] data_din;
  logic [3:0]           tag_web;
  logic [23:0]          tag_din;
  logic                 valid_din;
  // Replay pulses / status
  logic                 dfp_resp_reg;
  logic                 write_done_reg;
  logic                 busy;

  modport master (
    input  miss_req, hit_write, hit_way, req_addr, req_wmask, req_wdata,
           victim_way, victim_valid, victim_dirty, victim_tag, victim_data,
           dfp_rdata, dfp_resp,
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
           data_web, data_wmask, data_din, tag_web, tag_din, valid_din,
           dfp_resp_reg, write_done_reg, busy
  );

  modport slave (
    output miss_req, hit_write, hit_way, req_addr, req_wmask, req_wdata,
           victim_way, victim_valid, victim_dirty, victim_tag, victim_data,
           dfp_rdata, dfp_resp,
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
           data_web, data_wmask, data_din, tag_web, tag_din, valid_din,
           dfp_resp_reg, write_done_reg, busy
  );

endinterface

// File: rtl/cache_line_merge.sv
// Places a 32-bit store into a 256-bit line: replicated write data plus a per-byte line mask.
//   word     : store data
//   wmask    : byte mask within the word
//   word_idx : word index within the line (addr[4:2])
//   din      : word replicated across the line
//   bmask    : byte enables within the line
module cache_line_merge
  import cache_types::*;
(
  input  logic [31:0]            word,
  input  logic [3:0]             wmask,
  input  logic [2:0]             word_idx,
  output logic [LINE_BITS-1:0]   din,
  output logic [LINE_BITS/8-1:0] bmask
);

  always_comb begin
    din   = {(LINE_BITS / 32){word}};
    bmask = (LINE_BITS/8)'(wmask) << {word_idx, 2'b00};
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Refill controller downstream of cache stage 2. Owns the DFP bus and all SRAM write ports.
// Misses write back a dirty victim, fetch the line and install it; write hits perform a masked
// single-word write and set the dirty bit. One-cycle replay pulses go back to stage 2.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cache_refill_ctrl_if master (stage 2 request, DFP, SRAM write, pulses, busy)
//   perf_*   : saturating miss / write-back / write-hit counters, only when CACHE_PERF_CNT_EN
//              is defined
// SET_BITS must be >= 4 so the tag fits the 23-bit tag field.
module cache_refill_ctrl
  import cache_types::*;
#(
  parameter int unsigned SET_BITS = 4,
  parameter int unsigned NUM_WAYS = 4
) (
  input logic                 clk,
  input logic                 rst,
  cache_refill_ctrl_if.master bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_miss_cnt,
  output logic [31:0]         perf_wb_cnt,
  output logic [31:0]         perf_whit_cnt
`endif
);

  localparam int unsigned TAG_W   = tag_width(SET_BITS);
  localparam int unsigned TAG_LSB = OFFSET_BITS + SET_BITS;

  function automatic logic [NUM_WAYS-1:0] way_web(input logic [1:0] way);
    return ~(NUM_WAYS'(1) << way);
  endfunction

  refill_state_t state_q, state_d;
  refill_req_t   req_q, req_d;
  logic          dfp_resp_reg_q, dfp_resp_reg_d;
  logic          write_done_q, write_done_d;

  logic [LINE_BITS-1:0]   merge_din;
  logic [LINE_BITS/8-1:0] merge_bmask;

  cache_line_merge u_merge (
    .word     (bus.req_wdata),
    .wmask    (bus.req_wmask),
    .word_idx (bus.req_addr[4:2]),
    .din      (merge_din),
    .bmask    (merge_bmask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      req_q          <= '0;
      dfp_resp_reg_q <= 1'b0;
      write_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      dfp_resp_reg_q <= dfp_resp_reg_d;
      write_done_q   <= write_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    dfp_resp_reg_d = 1'b0;
    write_done_d   = 1'b0;
    bus.dfp_addr   = '0;
    bus.dfp_read   = 1'b0;
    bus.dfp_write  = 1'b0;
    bus.dfp_wdata  = '0;
    bus.data_web   = '1;
    bus.data_wmask = '0;
    bus.data_din   = '0;
    bus.tag_web    = '1;
    bus.tag_din    = '0;
    bus.valid_din  = 1'b0;

    // Reset masks everything so a late dfp_resp or stale request cannot write the arrays.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (bus.miss_req) begin
            req_d.addr  = bus.req_addr;
            req_d.way   = bus.victim_way;
            req_d.vtag  = TAG_FIELD_W'(bus.victim_tag);
            req_d.vdata = bus.victim_data;
            state_d     = (bus.victim_valid && bus.victim_dirty) ? StWriteback : StFill;
          end else if (bus.hit_write) begin
            bus.data_web   = way_web(bus.hit_way);
            bus.data_wmask = merge_bmask;
            bus.data_din   = merge_din;
            bus.tag_web    = way_web(bus.hit_way);
            bus.tag_din    = {1'b1, TAG_FIELD_W'(bus.req_addr[31:TAG_LSB])};
            bus.valid_din  = 1'b1;
            write_done_d   = 1'b1;
          end
        end
        StWriteback: begin
          // Request drops combinationally in the response cycle.
          bus.dfp_write = ~bus.dfp_resp;
          bus.dfp_addr  = {req_q.vtag[TAG_W-1:0], req_q.addr[TAG_LSB-1:OFFSET_BITS],
                           {OFFSET_BITS{1'b0}}};
          bus.dfp_wdata = req_q.vdata;
          if (bus.dfp_resp) begin
            state_d = StFill;
          end
        end
        StFill: begin
          bus.dfp_read = 1'b1;
          bus.dfp_addr = {req_q.addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          if (bus.dfp_resp) begin
            bus.data_web   = way_web(req_q.way);
            bus.data_wmask = '1;
            bus.data_din   = bus.dfp_rdata;
            bus.tag_web    = way_web(req_q.way);
            bus.tag_din    = {1'b0, TAG_FIELD_W'(req_q.addr[31:TAG_LSB])};
            bus.valid_din  = 1'b1;
            dfp_resp_reg_d = 1'b1;
            state_d        = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.dfp_resp_reg   = dfp_resp_reg_q;
  assign bus.write_done_reg = write_done_q;
  assign bus.busy           = (state_q != StIdle);

  logic unused_bits;
  assign unused_bits = ^{req_q.addr[OFFSET_BITS-1:0], bus.req_addr[1:0]};

`ifdef CACHE_PERF_CNT_EN
  logic        miss_acc, wb_done;
  logic [31:0] miss_cnt_q, wb_cnt_q, whit_cnt_q;

  assign miss_acc = (state_q == StIdle) && bus.miss_req;
  assign wb_done  = (state_q == StWriteback) && bus.dfp_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
      whit_cnt_q <= '0;
    end else begin
      if (miss_acc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (wb_done && (wb_cnt_q != '1)) wb_cnt_q <= wb_cnt_q + 32'd1;
      if (write_done_d && (whit_cnt_q != '1)) whit_cnt_q <= whit_cnt_q + 32'd1;
    end
  end

  assign perf_miss_cnt = miss_cnt_q;
  assign perf_wb_cnt   = wb_cnt_q;
  assign perf_whit_cnt = whit_cnt_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

  localparam int unsigned SET_BITS = 4;
  localparam int unsigned TAG_LSB  = 5 + SET_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_refill_ctrl_if #(.SET_BITS(SET_BITS)) bus ();

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] perf_miss_cnt, perf_wb_cnt, perf_whit_cnt;
`endif

  cache_refill_ctrl #(
    .SET_BITS (SET_BITS),
    .NUM_WAYS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_PERF_CNT_EN
    ,
    .perf_miss_cnt (perf_miss_cnt),
    .perf_wb_cnt   (perf_wb_cnt),
    .perf_whit_cnt (perf_whit_cnt)
`endif
  );

  typedef enum int {EvWrite, EvRead, EvSram, EvFillDone, EvWrDone} ev_kind_e;
  typedef struct {
    ev_kind_e      kind;
    logic [31:0]   addr;
    logic [255:0]  data;
    logic [3:0]    web;
    logic [31:0]   wmask;
    logic [23:0]   tdin;
    bit            fill;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  mdl_miss = 0, mdl_wb = 0, mdl_whit = 0;

  function automatic void check(input string name, input logic [255:0] got,
                                input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  function automatic void push_ev(input ev_kind_e k, input logic [31:0] a,
                                  input logic [255:0] d, input logic [3:0] w,
                                  input logic [31:0] m, input logic [23:0] t, input bit f);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.web = w; e.wmask = m; e.tdin = t; e.fill = f;
    exp_q.push_back(e);
  endfunction

  function automatic logic [3:0] exp_web(input logic [1:0] way);
    return 4'hF & ~(4'b0001 << way);
  endfunction

  function automatic logic [23:0] exp_tag(input bit dirty, input logic [31:0] addr);
    logic [31:0] t;
    t = addr >> TAG_LSB;
    return {dirty, t[22:0]};
  endfunction

  // Scoreboard: pop and compare whenever the DUT presents an observable event.
  task automatic pop_cmp(input ev_kind_e k);
    ev_t e;
    bit  ok;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got=%s exp=none", k.name());
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k) begin
      bad++;
      $display("FAIL event_order got=%s exp=%s", k.name(), e.kind.name());
      return;
    end
    ok = 1'b1;
    case (k)
      EvWrite: ok = (bus.dfp_addr === e.addr) && (bus.dfp_wdata === e.data);
      EvRead:  ok = (bus.dfp_addr === e.addr);
      EvSram:  ok = (bus.data_web === e.web) && (bus.tag_web === e.web) &&
                    (bus.data_wmask === e.wmask) && (bus.data_din === e.data) &&
                    (bus.tag_din === e.tdin) && (!e.fill || bus.valid_din === 1'b1);
      default: ok = 1'b1;
    endcase
    if (!ok) begin
      bad++;
      $display("FAIL %s got addr=%h web=%h tweb=%h mask=%h tag=%h din=%h exp addr=%h web=%h mask=%h tag=%h din=%h",
               k.name(), bus.dfp_addr, bus.data_web, bus.tag_web, bus.data_wmask, bus.tag_din,
               (k == EvWrite) ? bus.dfp_wdata : bus.data_din,
               e.addr, e.web, e.wmask, e.tdin, e.data);
    end
  endtask

  initial begin : monitor
    bit prev_rd, prev_wr;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rd = 1'b0;
        prev_wr = 1'b0;
      end else begin
        total++;
        if (bus.dfp_read && bus.dfp_write) begin
          bad++;
          $display("FAIL dfp_both got=rd%0b wr%0b exp=not both", bus.dfp_read, bus.dfp_write);
        end
        if (bus.dfp_resp_reg)   pop_cmp(EvFillDone);
        if (bus.write_done_reg) pop_cmp(EvWrDone);
        if (bus.dfp_write && !prev_wr) pop_cmp(EvWrite);
        if (bus.dfp_read && !prev_rd)  pop_cmp(EvRead);
        if (bus.data_web != 4'hF || bus.tag_web != 4'hF) pop_cmp(EvSram);
        prev_wr = bus.dfp_write;
        prev_rd = bus.dfp_read;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_line(output logic [255:0] l);
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
  endtask

  // Memory model: wait (bounded) for the request, respond after lat cycles.
  task automatic mem_resp(input bit rd, input int lat, input logic [255:0] rdata);
    int n;
    n = 0;
    while (!(rd ? bus.dfp_read : bus.dfp_write) && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      total++;
      bad++;
      $display("FAIL dfp_req_timeout got=none exp=%s", rd ? "read" : "write");
      return;
    end
    repeat (lat - 1) tick();
    bus.dfp_resp  = 1'b1;
    bus.dfp_rdata = rdata;
    tick();
    bus.dfp_resp  = 1'b0;
    bus.dfp_rdata = '0;
  endtask

  task automatic do_hit(input logic [1:0] way, input logic [31:0] addr,
                        input logic [3:0] wmask, input logic [31:0] wdata);
    int          widx;
    logic [31:0] m;
    widx = int'((addr >> 2) & 32'd7);
    m    = {28'b0, wmask} << (4 * widx);
    push_ev(EvSram, '0, {8{wdata}}, exp_web(way), m, exp_tag(1'b1, addr), 1'b0);
    push_ev(EvWrDone, '0, '0, '0, '0, '0, 1'b0);
    mdl_whit++;
    bus.hit_write = 1'b1;
    bus.hit_way   = way;
    bus.req_addr  = addr;
    bus.req_wmask = wmask;
    bus.req_wdata = wdata;
    tick();
    bus.hit_write = 1'b0;
    check("write_hit_latency", 256'(bus.write_done_reg), 256'd1);
  endtask

  task automatic do_miss(input logic [31:0] addr, input logic [1:0] way, input bit vvalid,
                         input bit vdirty, input logic [22:0] vtag, input logic [255:0] vdata,
                         input logic [255:0] rdata, input int lat_wb, input int lat_rd,
                         input bit with_hit, input bit write_miss);
    bit          dirty;
    logic [31:0] set_mask;
    dirty    = vvalid && vdirty;
    set_mask = ((32'd1 << SET_BITS) - 32'd1) << 5;
    if (dirty) push_ev(EvWrite, ({9'b0, vtag} << TAG_LSB) | (addr & set_mask), vdata,
                       '0, '0, '0, 1'b0);
    push_ev(EvRead, addr & ~32'd31, '0, '0, '0, '0, 1'b0);
    push_ev(EvSram, '0, rdata, exp_web(way), 32'hFFFF_FFFF, exp_tag(1'b0, addr), 1'b1);
    push_ev(EvFillDone, '0, '0, '0, '0, '0, 1'b0);
    mdl_miss++;
    if (dirty) mdl_wb++;
    bus.miss_req     = 1'b1;
    bus.hit_write    = with_hit;
    bus.hit_way      = 2'($urandom);
    bus.req_addr     = addr;
    bus.req_wmask    = 4'($urandom);
    bus.req_wdata    = $urandom;
    bus.victim_way   = way;
    bus.victim_valid = vvalid;
    bus.victim_dirty = vdirty;
    bus.victim_tag   = vtag;
    bus.victim_data  = vdata;
    tick();
    bus.miss_req  = 1'b0;
    bus.hit_write = 1'b0;
    if (dirty) mem_resp(1'b0, lat_wb, '0);
    mem_resp(1'b1, lat_rd, rdata);
    check("fill_pulse_latency", 256'(bus.dfp_resp_reg), 256'd1);
    // Stage 2 replays a write miss as a write hit in the pulse cycle.
    if (write_miss) do_hit(way, addr, 4'($urandom_range(1, 15)), $urandom);
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      bus.dfp_resp = ($urandom_range(0, 3) == 0);
      tick();
      bus.dfp_resp = 1'b0;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [255:0] pat_a, pat_b, line, rd;
    int           k;

    bus.miss_req = 1'b0; bus.hit_write = 1'b0; bus.hit_way = '0; bus.req_addr = '0;
    bus.req_wmask = '0; bus.req_wdata = '0; bus.victim_way = '0; bus.victim_valid = 1'b0;
    bus.victim_dirty = 1'b0; bus.victim_tag = '0; bus.victim_data = '0;
    bus.dfp_rdata = '0; bus.dfp_resp = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_dfp_read", 256'(bus.dfp_read), 256'd0);
    check("rst_dfp_write", 256'(bus.dfp_write), 256'd0);
    check("rst_busy", 256'(bus.busy), 256'd0);
    check("rst_dfp_resp_reg", 256'(bus.dfp_resp_reg), 256'd0);
    check("rst_write_done_reg", 256'(bus.write_done_reg), 256'd0);
    check("rst_data_web", 256'(bus.data_web), 256'hF);
    check("rst_tag_web", 256'(bus.tag_web), 256'hF);
    check("rst_dfp_addr", 256'(bus.dfp_addr), 256'd0);
    check("rst_dfp_wdata", bus.dfp_wdata, 256'd0);
    check("rst_data_din", bus.data_din, 256'd0);
    check("rst_data_wmask", 256'(bus.data_wmask), 256'd0);
    check("rst_tag_din", 256'(bus.tag_din), 256'd0);
    check("rst_valid_din", 256'(bus.valid_din), 256'd0);
    tick();

    // Directed cases
    pat_a = {8{32'hA5A5_0F0F}};
    pat_b = {8{32'h1234_BEEF}};
    do_miss(32'h0000_1240, 2'd2, 1'b0, 1'b0, 23'h0, pat_b, pat_a, 1, 5, 1'b0, 1'b0);
    tick();
    do_miss(32'h0000_5560, 2'd3, 1'b1, 1'b1, 23'h12, pat_b, pat_a ^ pat_b, 4, 3, 1'b0, 1'b0);
    tick();
    do_hit(2'd1, 32'h0000_0808, 4'b0110, 32'hAABB_CCDD);
    tick();
    do_miss(32'h00AB_CDE0, 2'd0, 1'b1, 1'b0, 23'h7, pat_b, ~pat_a, 1, 2, 1'b1, 1'b0);
    tick();
`ifdef CACHE_PERF_CNT_EN
    check("perf_miss_directed", 256'(perf_miss_cnt), 256'(mdl_miss));
    check("perf_wb_directed", 256'(perf_wb_cnt), 256'(mdl_wb));
    check("perf_whit_directed", 256'(perf_whit_cnt), 256'(mdl_whit));
`endif

    // Reset during write-back, late response afterwards
    push_ev(EvWrite, (32'h55 << TAG_LSB) | 32'h0000_0040, pat_b, '0, '0, '0, 1'b0);
    bus.miss_req = 1'b1; bus.req_addr = 32'hFFFF_F040; bus.victim_way = 2'd1;
    bus.victim_valid = 1'b1; bus.victim_dirty = 1'b1; bus.victim_tag = 23'h55;
    bus.victim_data = pat_b;
    tick();
    bus.miss_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.dfp_resp = 1'b1;
    bus.dfp_rdata = pat_a;
    @(negedge clk);
    check("midrst_busy", 256'(bus.busy), 256'd0);
    check("midrst_dfp_write", 256'(bus.dfp_write), 256'd0);
    check("midrst_data_web", 256'(bus.data_web), 256'hF);
    tick();
    bus.dfp_resp = 1'b0;
    tick();
    check("midrst_no_pulse", 256'(bus.dfp_resp_reg), 256'd0);
    mdl_miss = 0; mdl_wb = 0; mdl_whit = 0;

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 4);
      rand_line(line);
      rand_line(rd);
      case (k)
        0: do_hit(2'($urandom), $urandom, 4'($urandom), $urandom);
        1: do_miss($urandom, 2'($urandom), 1'($urandom), 1'b0, 23'($urandom), line, rd,
                   1, $urandom_range(1, 6), 1'b0, 1'($urandom));
        2: do_miss($urandom, 2'($urandom), 1'b1, 1'b1, 23'($urandom), line, rd,
                   $urandom_range(1, 6), $urandom_range(1, 6), 1'b0, 1'($urandom));
        3: do_miss($urandom, 2'($urandom), 1'b0, 1'b1, 23'($urandom), line, rd,
                   1, $urandom_range(1, 6), 1'b0, 1'b0);
        default: do_miss($urandom, 2'($urandom), 1'($urandom), 1'($urandom), 23'($urandom),
                         line, rd, $urandom_range(1, 6), $urandom_range(1, 6), 1'b1,
                         1'($urandom));
      endcase
      idle_gap();
    end

    repeat (3) tick();
    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
`ifdef CACHE_PERF_CNT_EN
    check("perf_miss_random", 256'(perf_miss_cnt), 256'(mdl_miss));
    check("perf_wb_random", 256'(perf_wb_cnt), 256'(mdl_wb));
    check("perf_whit_random", 256'(perf_whit_cnt), 256'(mdl_whit));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
